rom_6502_loader: RTL and testbench

- Write-side companion to the 6502 boot ROM line memory (256 lines x 128 bits, byte-addressed 12-bit space).
- Byte offset 0 of a line is bits [127:120] and offset F is bits [7:0].
- Accepts a byte-wide download stream (HPS/ioctl style) and packs the bytes into 128-bit lines with a 16-bit byte-enable.
- Issues line writes to the ROM memory's write port through a request/ack handshake, so an arbiter can share the memory with the 6502 read path.

---
 rtl/rom_6502_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_rom_6502_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_6502_loader.sv
// Byte-stream to 128-bit line packer feeding the 6502 boot ROM write port.
// Optional ROM_6502_LOADER_CHECKSUM_EN adds a running byte checksum output.
module rom_6502_loader #(
  parameter int ADDR_W        = 12,
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              dl_done,
  output logic              dl_ready,
  output logic              mem_we,
  output logic [ADDR_W-5:0] mem_addr,
  output logic [127:0]      mem_data,
  output logic [15:0]       mem_be,
  input  logic              mem_ack,
  output logic              busy,
`ifdef ROM_6502_LOADER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              done
);

  localparam int LW = ADDR_W - 4;
  localparam int TW = (FLUSH_TIMEOUT > 0) ?
                      $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     line_q, line_d;
  logic [127:0]      buf_q, buf_d;
  logic [15:0]       be_q, be_d;
  logic              skv_q, skv_d;
  logic [ADDR_W-1:0] ska_q, ska_d;
  logic [7:0]        skd_q, skd_d;
  logic              dreq_q, dreq_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic          acc;
  logic [3:0]    off;
  logic [LW-1:0] ln;
  logic [3:0]    sk_off;
  logic [LW-1:0] sk_ln;
  logic          tmo_hit;

  function automatic logic [127:0] put(
    input logic [127:0] b,
    input logic [3:0]   o,
    input logic [7:0]   d
  );
    logic [127:0] r;
    r = b;
    r[8*(15-int'(o)) +: 8] = d;
    return r;
  endfunction

  function automatic logic [15:0] bsel(input logic [3:0] o);
    return 16'h8000 >> o;
  endfunction

  assign acc    = dl_wr & rdy_q;
  assign off    = dl_addr[3:0];
  assign ln     = dl_addr[ADDR_W-1:4];
  assign sk_off = ska_q[3:0];
  assign sk_ln  = ska_q[ADDR_W-1:4];
  assign tmo_hit = (FLUSH_TIMEOUT > 0) &&
    (32'(tmo_q) + 32'd1 == 32'(FLUSH_TIMEOUT));

`ifdef ROM_6502_LOADER_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;
  logic        cclr_q, cclr_d;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    buf_d   = buf_q;
    be_d    = be_q;
    skv_d   = skv_q;
    ska_d   = ska_q;
    skd_d   = skd_q;
    dreq_d  = dreq_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          line_d  = ln;
          buf_d   = put('0, off, dl_data);
          be_d    = bsel(off);
          tmo_d   = '0;
          dreq_d  = dl_done;
          state_d = (off == 4'hF || dl_done) ? FLUSH : FILL;
        end else if (dl_done) begin
          done_d = 1'b1;
        end
      end
      FILL: begin
        if (acc && ln == line_q) begin
          buf_d  = put(buf_q, off, dl_data);
          be_d   = be_q | bsel(off);
          tmo_d  = '0;
          dreq_d = dl_done;
          if (off == 4'hF || dl_done) state_d = FLUSH;
        end else if (acc) begin
          // new line parks in the skid while the old one drains
          skv_d   = 1'b1;
          ska_d   = dl_addr;
          skd_d   = dl_data;
          dreq_d  = dl_done;
          state_d = FLUSH;
        end else if (dl_done) begin
          dreq_d  = 1'b1;
          state_d = FLUSH;
        end else if (tmo_hit) begin
          state_d = FLUSH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      FLUSH: begin
        dreq_d = dreq_q | dl_done;
        if (mem_ack) begin
          if (skv_q) begin
            line_d  = sk_ln;
            buf_d   = put('0, sk_off, skd_q);
            be_d    = bsel(sk_off);
            skv_d   = 1'b0;
            tmo_d   = '0;
            state_d = (sk_off == 4'hF || dreq_d) ? FLUSH : FILL;
          end else begin
            buf_d   = '0;
            be_d    = '0;
            state_d = EMPTY;
            if (dreq_d) begin
              done_d = 1'b1;
              dreq_d = 1'b0;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d  = (state_d != FLUSH);
    we_d   = (state_d == FLUSH);
    busy_d = (state_d != EMPTY);
  end

`ifdef ROM_6502_LOADER_CHECKSUM_EN
  always_comb begin
    cs_d   = cs_q;
    cclr_d = cclr_q;
    if (acc) begin
      cs_d   = (cclr_q ? 16'd0 : cs_q) + {8'd0, dl_data};
      cclr_d = 1'b0;
    end
    if (done_d) cclr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= '0;
      cclr_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      cclr_q <= cclr_d;
    end
  end

  assign checksum = cs_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      line_q  <= '0;
      buf_q   <= '0;
      be_q    <= '0;
      skv_q   <= 1'b0;
      ska_q   <= '0;
      skd_q   <= '0;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
      be_q    <= be_d;
      skv_q   <= skv_d;
      ska_q   <= ska_d;
      skd_q   <= skd_d;
      dreq_q  <= dreq_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dl_ready = rdy_q;
  assign mem_we   = we_q;
  assign mem_addr = line_q;
  assign mem_data = buf_q;
  assign mem_be   = be_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rom_6502_loader.sv
// Directed bench for rom_6502_loader with a byte-level line model.
// Checksum checks are active when ROM_6502_LOADER_CHECKSUM_EN is defined.
module tb_rom_6502_loader;

  logic         clk = 0;
  logic         reset = 1;
  logic         dl_wr = 0;
  logic [11:0]  dl_addr = '0;
  logic [7:0]   dl_data = '0;
  logic         dl_done = 0;
  logic         dl_ready, mem_we, mem_ack, busy, done;
  logic [7:0]   mem_addr;
  logic [127:0] mem_data;
  logic [15:0]  mem_be;
`ifdef ROM_6502_LOADER_CHECKSUM_EN
  logic [15:0]  checksum;
  logic [15:0]  cs_at_done = '0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic ack_tie = 0;
  int   ack_delay = 0;
  int   wcnt = 0;
  always @(posedge clk) wcnt <= (mem_we && !mem_ack) ? wcnt + 1 : 0;
  assign mem_ack = ack_tie | (mem_we && wcnt >= ack_delay);

  rom_6502_loader dut (
    .clk      (clk),
    .reset    (reset),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_done  (dl_done),
    .dl_ready (dl_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .busy     (busy),
`ifdef ROM_6502_LOADER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .done     (done)
  );

  typedef struct packed {
    logic [7:0]   a;
    logic [127:0] d;
    logic [15:0]  be;
  } wr_t;

  wr_t expq[$];
  wr_t wlog[$];
  int  runlog[$];

  logic [7:0] mb [16];
  bit         mv [16];
  logic [7:0] m_line = '0;
  int done_exp = 0;
  int done_seen = 0;
  int rdy_low = 0;
  int run = 0;
  bit p_we = 0, p_ack = 0, p_din = 0;
  logic [7:0]   p_addr;
  logic [127:0] p_data;
  logic [15:0]  p_be;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit m_any();
    for (int i = 0; i < 16; i++) if (mv[i]) return 1;
    return 0;
  endfunction

  task automatic m_push();
    wr_t w;
    w.a = m_line;
    w.d = '0;
    w.be = '0;
    for (int i = 0; i < 16; i++)
      if (mv[i]) begin
        w.d[127-8*i -: 8] = mb[i];
        w.be[15-i] = 1'b1;
        mv[i] = 0;
      end
    expq.push_back(w);
  endtask

  task automatic m_byte(logic [11:0] a, logic [7:0] d);
    int o;
    o = int'(a[3:0]);
    if (m_any() && a[11:4] != m_line) m_push();
    m_line = a[11:4];
    mb[o] = d;
    mv[o] = 1;
    if (o == 15) m_push();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mv[i] = 0;
      expq.delete();
      done_exp = 0;
      run = 0;
      p_we = 0;
      p_ack = 0;
      p_din = 0;
    end else begin
      wr_t w, e;
      chk("ready_vs_we", 128'(dl_ready), 128'(!mem_we));
      if (mem_we) chk("busy_when_we", 128'(busy), 128'(1));
      if (!dl_ready) rdy_low++;
      if (p_we && !p_ack && mem_we) begin
        chk("hold_addr", 128'(mem_addr), 128'(p_addr));
        chk("hold_data", mem_data, p_data);
        chk("hold_be", 128'(mem_be), 128'(p_be));
      end
      if (mem_we) run++;
      if (mem_we && mem_ack) begin
        runlog.push_back(run);
        run = 0;
        w.a = mem_addr;
        w.d = mem_data;
        w.be = mem_be;
        wlog.push_back(w);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got line %0h want none", mem_addr);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", 128'(w.a), 128'(e.a));
          chk("wr_data", w.d, e.d);
          chk("wr_be", 128'(w.be), 128'(e.be));
        end
      end else if (!mem_we) begin
        run = 0;
      end
      if (done) begin
        done_seen++;
        chk("done_expected", 128'(done_exp > 0), 128'(1));
        chk("done_queue_empty", 128'(expq.size()), 128'(0));
        chk("done_after_ack", 128'(p_ack || p_din), 128'(1));
        if (done_exp > 0) done_exp--;
`ifdef ROM_6502_LOADER_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end
      if (dl_wr && dl_ready) m_byte(dl_addr, dl_data);
      if (dl_done) begin
        if (m_any()) m_push();
        done_exp++;
      end
      p_we = mem_we;
      p_ack = mem_we && mem_ack;
      p_din = dl_done;
      p_addr = mem_addr;
      p_data = mem_data;
      p_be = mem_be;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [11:0] a, logic [7:0] d, logic dn = 0);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    dl_wr = 1;
    dl_addr = a;
    dl_data = d;
    dl_done = dn;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = dl_ready;
      tick();
      n++;
    end
    dl_wr = 0;
    dl_done = 0;
    chk("send_accept", 128'(ok), 128'(1));
  endtask

  task automatic pulse_done();
    dl_done = 1;
    tick();
    dl_done = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while ((busy || expq.size() != 0 || done_exp != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", 128'(n < 300), 128'(1));
  endtask

  int n0, r0, d0;
  logic [127:0] ex;

  initial begin
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 128'(dl_ready), 128'(1));
    chk("rst_we", 128'(mem_we), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_be", 128'(mem_be), 128'(0));
    chk("rst_data", mem_data, 128'(0));
    tick();

    // full sequential line, ack tied high
    ack_tie = 1;
    rdy_low = 0;
    n0 = wlog.size();
    for (int i = 0; i < 16; i++) send(12'(i), 8'(i));
    wait_idle();
    chk("t1_nwr", 128'(wlog.size() - n0), 128'(1));
    chk("t1_addr", 128'(wlog[n0].a), 128'(0));
    chk("t1_data", wlog[n0].d,
        128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_be", 128'(wlog[n0].be), 128'hFFFF);
    chk("t1_rdy_low", 128'(rdy_low), 128'(1));
    ack_tie = 0;

    // line change then done
    n0 = wlog.size();
    d0 = done_seen;
    send(12'h123, 8'hAA);
    send(12'h200, 8'h55);
    pulse_done();
    wait_idle();
    chk("t2_nwr", 128'(wlog.size() - n0), 128'(2));
    chk("t2_a0", 128'(wlog[n0].a), 128'h12);
    chk("t2_be0", 128'(wlog[n0].be), 128'h1000);
    ex = 128'hAA << 96;
    chk("t2_d0", wlog[n0].d, ex);
    chk("t2_a1", 128'(wlog[n0+1].a), 128'h20);
    chk("t2_be1", 128'(wlog[n0+1].be), 128'h8000);
    ex = 128'h55 << 120;
    chk("t2_d1", wlog[n0+1].d, ex);
    chk("t2_done", 128'(done_seen - d0), 128'(1));

    // slow ack with skid pending
    ack_delay = 4;
    n0 = wlog.size();
    r0 = runlog.size();
    send(12'h300, 8'h01);
    send(12'h301, 8'h02);
    send(12'h302, 8'h03);
    send(12'h410, 8'h04);
    send(12'h411, 8'h05);
    pulse_done();
    wait_idle();
    chk("t3_nwr", 128'(wlog.size() - n0), 128'(2));
    chk("t3_run", 128'(runlog[r0]), 128'(5));
    chk("t3_be0", 128'(wlog[n0].be), 128'hE000);
    ex = 128'h010203 << 104;
    chk("t3_d0", wlog[n0].d, ex);
    chk("t3_a1", 128'(wlog[n0+1].a), 128'h41);
    ex = 128'h0405 << 112;
    chk("t3_d1", wlog[n0+1].d, ex);
    ack_delay = 0;

    // rewrite of an enabled offset
    n0 = wlog.size();
    send(12'h010, 8'h11);
    send(12'h010, 8'h22);
    send(12'h01F, 8'h33);
    wait_idle();
    chk("t4_nwr", 128'(wlog.size() - n0), 128'(1));
    chk("t4_a", 128'(wlog[n0].a), 128'h01);
    chk("t4_be", 128'(wlog[n0].be), 128'h8001);
    ex = (128'h22 << 120) | 128'h33;
    chk("t4_d", wlog[n0].d, ex);

    // reset while a write is pending
    ack_delay = 8;
    send(12'h050, 8'h01);
    send(12'h05F, 8'h02);
    tick();
    tick();
    chk("t5_we_pend", 128'(mem_we), 128'(1));
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("t5_we", 128'(mem_we), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_ready", 128'(dl_ready), 128'(1));
    tick();
    ack_delay = 0;
    n0 = wlog.size();
    send(12'h065, 8'h77);
    pulse_done();
    wait_idle();
    chk("t5_nwr", 128'(wlog.size() - n0), 128'(1));
    chk("t5_a", 128'(wlog[n0].a), 128'h06);
    chk("t5_be", 128'(wlog[n0].be), 128'h0400);
    ex = 128'h77 << 80;
    chk("t5_d", wlog[n0].d, ex);

    // byte and done in the same cycle
    n0 = wlog.size();
    d0 = done_seen;
    send(12'h7A3, 8'h5A, 1'b1);
    wait_idle();
    chk("t6_nwr", 128'(wlog.size() - n0), 128'(1));
    chk("t6_a", 128'(wlog[n0].a), 128'h7A);
    chk("t6_be", 128'(wlog[n0].be), 128'h1000);
    chk("t6_done", 128'(done_seen - d0), 128'(1));

    // done with nothing pending
    n0 = wlog.size();
    d0 = done_seen;
    pulse_done();
    wait_idle();
    chk("t7_nwr", 128'(wlog.size() - n0), 128'(0));
    chk("t7_done", 128'(done_seen - d0), 128'(1));

    // long stream of FF bytes
    reset = 1;
    tick();
    reset = 0;
    tick();
    n0 = wlog.size();
    for (int i = 0; i < 300; i++) send(12'(i), 8'hFF);
    pulse_done();
    wait_idle();
    chk("t8_nwr", 128'(wlog.size() - n0), 128'(19));
`ifdef ROM_6502_LOADER_CHECKSUM_EN
    chk("t8_checksum", 128'(cs_at_done), 128'h2AD4);
`endif

    chk("end_queue", 128'(expq.size()), 128'(0));
    chk("end_done", 128'(done_exp), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
